// File: rtl/multicycle_main_controller_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// opcodes and the mux/ALU-op encodings used by the datapath and ALU decoder.
package multicycle_main_controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_decode(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_LW, OP_I: imm = IMM_I;
      OP_SW:       imm = IMM_S;
      OP_BEQ:      imm = IMM_B;
      OP_JAL:      imm = IMM_J;
      default:     imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Memory handshake between the main controller (master) and the unified
// instruction/data memory (slave).
interface multicycle_main_controller_if;
  logic mem_req;
  logic mem_we;
  logic AdrSrc;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output AdrSrc, input mem_ready);
  modport slave  (input mem_req, input mem_we, input AdrSrc, output mem_ready);
endinterface

// File: rtl/multicycle_main_controller_instret_counter.sv
// Retired-instruction counter: increments on enable, wraps modulo 2^INSTRET_W.
module instret_counter #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [INSTRET_W-1:0] count
);

  logic [INSTRET_W-1:0] count_r;

  // Count register; natural overflow provides the wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU,
// register file and unified memory, and counts retired instructions.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_main_controller_if.master  mem,
  input  logic [6:0]                    opcode,
  input  logic                          Zero,
  output logic                          IRWrite,
  output logic                          pc_write,
  output logic                          RegWrite,
  output logic [1:0]                    ALUSrcA,
  output logic [1:0]                    ALUSrcB,
  output logic [1:0]                    ResultSrc,
  output logic [1:0]                    ImmSrc,
  output logic [1:0]                    ALU_op,
  output logic                          illegal_instr,
  output logic [INSTRET_W-1:0]          instret
);

  state_t     state_r;
  state_t     state_next_s;
  logic       mem_req_s;
  logic       mem_we_s;
  logic       adr_src_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_op_s;
  logic       retire_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Moore output decode (memory states qualified by mem_ready).
  always_comb begin
    state_next_s = state_r;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_REGB;
    result_src_s = RES_ALUOUT;
    alu_op_s     = ALU_OP_ADD;
    retire_s     = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        if (mem.mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = DECODE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_R:         state_next_s = EXECUTER;
          OP_I:         state_next_s = EXECUTEI;
          OP_BEQ:       state_next_s = BEQ;
          OP_JAL:       state_next_s = JAL;
          default:      state_next_s = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a_s = SRCA_REGA;
        alu_src_b_s = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_next_s = MEMREAD;
        end else begin
          state_next_s = MEMWRITE;
        end
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem.mem_ready) begin
          state_next_s = MEMWB;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMWB: begin
        result_src_s = RES_MEMDATA;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        adr_src_s = 1'b1;
        if (mem.mem_ready) begin
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end else begin
          state_next_s = MEMWRITE;
        end
      end
      EXECUTER: begin
        alu_src_a_s  = SRCA_REGA;
        alu_src_b_s  = SRCB_REGB;
        alu_op_s     = ALU_OP_FUNC;
        state_next_s = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a_s  = SRCA_REGA;
        alu_src_b_s  = SRCB_IMM;
        alu_op_s     = ALU_OP_FUNC;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      BEQ: begin
        alu_src_a_s  = SRCA_REGA;
        alu_src_b_s  = SRCB_REGB;
        alu_op_s     = ALU_OP_SUB;
        result_src_s = RES_ALUOUT;
        pc_write_s   = Zero;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      JAL: begin
        // Target was precomputed in DECODE; ALU now forms the link value PC+4.
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALUOUT;
        pc_write_s   = 1'b1;
        state_next_s = ALUWB;
      end
      ILLEGAL: begin
        state_next_s = ILLEGAL;
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // Gating with rst_n keeps FETCH's request and selects quiet during reset.
  assign mem.mem_req   = rst_n & mem_req_s;
  assign mem.mem_we    = rst_n & mem_we_s;
  assign mem.AdrSrc    = rst_n & adr_src_s;
  assign IRWrite       = rst_n & ir_write_s;
  assign pc_write      = rst_n & pc_write_s;
  assign RegWrite      = rst_n & reg_write_s;
  assign ALUSrcA       = rst_n ? alu_src_a_s  : 2'b00;
  assign ALUSrcB       = rst_n ? alu_src_b_s  : 2'b00;
  assign ResultSrc     = rst_n ? result_src_s : 2'b00;
  assign ALU_op        = rst_n ? alu_op_s     : 2'b00;
  assign ImmSrc        = rst_n ? imm_src_decode(opcode) : 2'b00;
  assign illegal_instr = rst_n & (state_r == ILLEGAL);

  instret_counter #(
    .INSTRET_W (INSTRET_W)
  ) u_instret_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_s),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Randomized bench for multicycle_main_controller: each instruction is expanded
// into its list of phases and the per-cycle outputs are predicted from that list.
module tb_multicycle_main_controller;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   opcode = 7'b0110011;
  logic         Zero = 1'b0;
  logic         IRWrite, pc_write, RegWrite, illegal_instr;
  logic [1:0]   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALU_op;
  logic [W-1:0] instret;
  logic [16:0]  dut_vec;

  int checks = 0;
  int fails = 0;
  int model_instret = 0;
  string plan[$];

  multicycle_main_controller_if bus ();

  multicycle_main_controller #(.INSTRET_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (bus),
    .opcode        (opcode),
    .Zero          (Zero),
    .IRWrite       (IRWrite),
    .pc_write      (pc_write),
    .RegWrite      (RegWrite),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ResultSrc     (ResultSrc),
    .ImmSrc        (ImmSrc),
    .ALU_op        (ALU_op),
    .illegal_instr (illegal_instr),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  assign dut_vec = {bus.mem_req, bus.mem_we, bus.AdrSrc, IRWrite, pc_write, RegWrite,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALU_op, illegal_instr};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Expected output vector for one phase, straight from the per-state tables.
  function automatic logic [16:0] expect_vec(input string st, input logic rdy,
                                             input logic z, input logic [6:0] op);
    logic mreq, mwe, adr, irw, pcw, rw, ill;
    logic [1:0] a, b, res, aop;
    mreq = 1'b0; mwe = 1'b0; adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; ill = 1'b0;
    a = 2'b00; b = 2'b00; res = 2'b00; aop = 2'b00;
    if (st == "FETCH") begin
      mreq = 1'b1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy;
    end else if (st == "DECODE") begin
      a = 2'b01; b = 2'b01;
    end else if (st == "MEMADR") begin
      a = 2'b10; b = 2'b01;
    end else if (st == "MEMREAD") begin
      mreq = 1'b1; adr = 1'b1;
    end else if (st == "MEMWB") begin
      res = 2'b01; rw = 1'b1;
    end else if (st == "MEMWRITE") begin
      mreq = 1'b1; mwe = 1'b1; adr = 1'b1;
    end else if (st == "EXECUTER") begin
      a = 2'b10; aop = 2'b10;
    end else if (st == "EXECUTEI") begin
      a = 2'b10; b = 2'b01; aop = 2'b10;
    end else if (st == "ALUWB") begin
      rw = 1'b1;
    end else if (st == "BEQ") begin
      a = 2'b10; aop = 2'b01; pcw = z;
    end else if (st == "JAL") begin
      a = 2'b01; b = 2'b10; pcw = 1'b1;
    end else begin
      ill = 1'b1;
    end
    return {mreq, mwe, adr, irw, pcw, rw, a, b, res, imm_of(op), aop, ill};
  endfunction

  function automatic void build_plan(input logic [6:0] op);
    plan.delete();
    plan.push_back("FETCH");
    plan.push_back("DECODE");
    case (op)
      7'b0000011: begin plan.push_back("MEMADR"); plan.push_back("MEMREAD"); plan.push_back("MEMWB"); end
      7'b0100011: begin plan.push_back("MEMADR"); plan.push_back("MEMWRITE"); end
      7'b0110011: begin plan.push_back("EXECUTER"); plan.push_back("ALUWB"); end
      7'b0010011: begin plan.push_back("EXECUTEI"); plan.push_back("ALUWB"); end
      7'b1100011: plan.push_back("BEQ");
      7'b1101111: begin plan.push_back("JAL"); plan.push_back("ALUWB"); end
      default: for (int i = 0; i < 20; i++) plan.push_back("ILLEGAL");
    endcase
  endfunction

  function automatic logic [6:0] random_legal_op();
    logic [6:0] ops [6];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    return ops[$urandom_range(0, 5)];
  endfunction

  // Walk one instruction; mem_waits < 0 means random memory latency,
  // zmode < 0 means random Zero. Starts and ends just after a rising edge.
  task automatic run_instr(input logic [6:0] op, input int mem_waits, input int zmode);
    string st;
    logic  rdy;
    int    waits;
    bit    legal;
    waits = 0;
    build_plan(op);
    legal = (plan[plan.size()-1] != "ILLEGAL");
    opcode = op;
    while (plan.size() > 0) begin
      st = plan[0];
      if (mem_waits < 0) rdy = ($urandom_range(0, 2) != 0) || (waits >= 4);
      else if (st == "FETCH") rdy = 1'b1;
      else rdy = (waits >= mem_waits);
      bus.mem_ready = rdy;
      Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      check_eq({"out_", st}, {15'd0, dut_vec}, {15'd0, expect_vec(st, rdy, Zero, op)});
      @(posedge clk);
      #1;
      if ((st == "FETCH" || st == "MEMREAD" || st == "MEMWRITE") && !rdy) begin
        waits++;
      end else begin
        waits = 0;
        void'(plan.pop_front());
      end
    end
    if (legal) model_instret = (model_instret + 1) % (1 << W);
    check_eq("instret", {{(32-W){1'b0}}, instret}, model_instret);
  endtask

  initial begin
    bus.mem_ready = 1'b1;
    #2;
    check_eq("reset_outputs", {15'd0, dut_vec}, 32'd0);
    check_eq("reset_instret", {{(32-W){1'b0}}, instret}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(7'b0110011, 0, -1);           // R-type, ready throughout
    run_instr(7'b0000011, 3, -1);           // lw with three memory wait cycles
    run_instr(7'b1100011, 0, 1);            // beq taken
    run_instr(7'b1100011, 0, 0);            // beq not taken
    run_instr(7'b1101111, 0, -1);           // jal
    while (model_instret != (1 << W) - 1) run_instr(random_legal_op(), -1, -1);
    run_instr(7'b0100011, -1, -1);          // sw retiring at all-ones wraps to 0
    check_eq("wrap_zero", {{(32-W){1'b0}}, instret}, 32'd0);
    for (int n = 0; n < 30; n++) run_instr(random_legal_op(), -1, -1);

    // Reset in the middle of a store held waiting in MEMWRITE.
    opcode = 7'b0100011;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_eq("memwrite_we", {31'd0, bus.mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_we_drop", {31'd0, bus.mem_we}, 32'd0);
    check_eq("async_outputs", {15'd0, dut_vec}, 32'd0);
    check_eq("async_instret", {{(32-W){1'b0}}, instret}, 32'd0);
    model_instret = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(7'b0010011, -1, -1);          // restarts cleanly from FETCH

    // Illegal opcode halts the core until the next reset.
    run_instr(7'b1111111, -1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("illegal_cleared", {31'd0, illegal_instr}, 32'd0);
    model_instret = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(7'b0110011, -1, -1);
    for (int n = 0; n < 10; n++) run_instr(random_legal_op(), -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
